// File: rtl/station_scheduler.sv
// station_scheduler
// Issue scheduler and dispatch allocator for the four reservation stations.
// Each cycle it offers the lowest-index free station to the decoder. It
// issues at most one ready station: the oldest one with no register or
// memory hazard against any older in-flight station. Age is kept in an
// order queue, q[0] being the oldest.
//
// Ports
//   clk, a_rst        clock, asynchronous active-low reset
//   id_valid/id_ready decoder dispatch handshake (see below)
//   st_feed           one-hot dispatch strobe to the chosen station
//   st_ready          per-station uOp ready
//   st_will_complete  per-station "current uOp is the final one"
//   st_a_adr/b_adr    3-bit source registers per station
//   st_bypass_b       B operand is a constant, ignore b_adr
//   st_d_adr          {we, reg[2:0]} destination per station
//   st_ld_mem         current uOp loads from memory
//   st_lock_loads     station blocks younger loads
//   st_lock_reg_wr    {valid, reg[2:0]} terminal write lock per station
//   st_lock_reg_rd    three 3-bit terminal read locks per station
//   ex_ready          execution stage accepts a uOp this cycle
//   st_ack            one-hot issue acknowledge to the station
//   iss_valid/iss_sel issue strobe and selected station index
//   occupancy         number of allocated stations (0..4)
//
// Handshakes: a dispatch transfer happens on a clock edge where
// id_valid & id_ready; an issue transfer happens on a clock edge where
// iss_valid (candidate present & ex_ready). Nothing moves otherwise, so a
// stalled candidate is presented unchanged on the following cycle.
module station_scheduler #(
    parameter int NST = 4
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        id_valid,
    output logic        id_ready,
    output logic [3:0]  st_feed,
    input  logic [3:0]  st_ready,
    input  logic [3:0]  st_will_complete,
    input  logic [11:0] st_a_adr,
    input  logic [11:0] st_b_adr,
    input  logic [3:0]  st_bypass_b,
    input  logic [15:0] st_d_adr,
    input  logic [3:0]  st_ld_mem,
    input  logic [3:0]  st_lock_loads,
    input  logic [15:0] st_lock_reg_wr,
    input  logic [35:0] st_lock_reg_rd,
    input  logic        ex_ready,
    output logic [3:0]  st_ack,
    output logic        iss_valid,
    output logic [1:0]  iss_sel,
    output logic [2:0]  occupancy
);

    logic [NST-1:0] alloc;
    logic [1:0]     q [NST];
    logic [2:0]     q_cnt;

    logic [NST-1:0] alloc_n;
    logic [1:0]     q_n [NST];
    logic [2:0]     cnt_n;
    logic [2:0]     cnt_mid;

    logic [1:0]     feed_idx;
    logic [NST-1:0] hz [NST];   // hz[c][o]: station c conflicts with station o
    logic           found;
    logic [1:0]     cand_pos;
    logic [1:0]     cand;
    logic [NST-1:0] ret_mask;
    logic           retire;
    logic           dispatch;

    // Dispatch: lowest-index free station.
    always_comb begin
        feed_idx = 2'd0;
        for (int i = NST - 1; i >= 0; i--) begin
            if (!alloc[i]) feed_idx = 2'(i);
        end
    end

    assign id_ready = ~&alloc;
    assign dispatch = id_valid & id_ready;
    assign st_feed  = dispatch ? (4'b0001 << feed_idx) : 4'b0000;

    // Pairwise hazard matrix; only applied later for o older than c.
    always_comb begin
        logic       wr_v;
        logic [2:0] wr_r;
        logic       d_we;
        logic [2:0] d_r;
        logic       raw, waw, war, mem;
        for (int c = 0; c < NST; c++) begin
            for (int o = 0; o < NST; o++) begin
                wr_v = st_lock_reg_wr[o*4+3];
                wr_r = st_lock_reg_wr[o*4 +: 3];
                d_we = st_d_adr[c*4+3];
                d_r  = st_d_adr[c*4 +: 3];
                raw  = wr_v & ((wr_r == st_a_adr[c*3 +: 3]) |
                               (~st_bypass_b[c] & (wr_r == st_b_adr[c*3 +: 3])));
                waw  = d_we & wr_v & (wr_r == d_r);
                war  = d_we & ((d_r == st_lock_reg_rd[o*9 +: 3]) |
                               (d_r == st_lock_reg_rd[o*9+3 +: 3]) |
                               (d_r == st_lock_reg_rd[o*9+6 +: 3]));
                mem  = st_ld_mem[c] & st_lock_loads[o];
                hz[c][o] = raw | waw | war | mem;
            end
        end
    end

    // Oldest-first scan of the order queue. A station is blocked by every
    // older entry whether or not that older entry is itself ready.
    always_comb begin
        logic blocked;
        found    = 1'b0;
        cand_pos = 2'd0;
        cand     = 2'd0;
        for (int p = 0; p < NST; p++) begin
            blocked = 1'b0;
            for (int j = 0; j < p; j++) begin
                blocked = blocked | hz[q[p]][q[j]];
            end
            if (!found && (3'(p) < q_cnt) && st_ready[q[p]] && !blocked) begin
                found    = 1'b1;
                cand_pos = 2'(p);
                cand     = q[p];
            end
        end
    end

    assign iss_valid = found & ex_ready;
    assign iss_sel   = cand;
    assign st_ack    = iss_valid ? (4'b0001 << cand) : 4'b0000;
    assign ret_mask  = st_ack & st_will_complete;
    assign retire    = |ret_mask;

    // Remove the retiring entry first, then append the dispatched one at
    // the post-removal tail, so a same-cycle retire+dispatch keeps q_cnt.
    always_comb begin
        for (int p = 0; p < NST; p++) q_n[p] = q[p];
        if (retire) begin
            for (int p = 0; p < NST - 1; p++) begin
                if (2'(p) >= cand_pos) q_n[p] = q[p+1];
            end
            q_n[NST-1] = 2'd0;
        end
        cnt_mid = q_cnt - {2'b00, retire};
        if (dispatch) q_n[cnt_mid[1:0]] = feed_idx;
        cnt_n   = cnt_mid + {2'b00, dispatch};
        alloc_n = (alloc & ~ret_mask) | st_feed;
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            alloc <= '0;
            q_cnt <= '0;
            for (int p = 0; p < NST; p++) q[p] <= '0;
        end else begin
            alloc <= alloc_n;
            q_cnt <= cnt_n;
            for (int p = 0; p < NST; p++) q[p] <= q_n[p];
        end
    end

    assign occupancy = q_cnt;

endmodule

// File: doc/station_scheduler.md
# station_scheduler

Issue scheduler and dispatch allocator for four reservation stations in the 65HE06 core. Each cycle it gives one free station to the instruction decoder. It also selects at most one ready station for execution: the oldest one with no register or memory hazard against older in-flight stations. It tracks station age in an order queue, pulses the per-station scheduler acknowledge, and frees a station when its final micro-operation issues.

## Interface
Parameters:
- NST, 4, number of stations; fixed at 4 (2-bit station index).

Ports (per-station buses are packed, station i at slice i):
- clk  in  1  clock.
- a_rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decoder has an instruction to dispatch.
- id_ready  out  1  at least one station is free.
- st_feed  out  4  one-hot dispatch strobe, to station id_feed.
- st_ready  in  4  station r_ready.
- st_will_complete  in  4  station r_will_complete.
- st_a_adr  in  12  3 bits per station, r_a_adr.
- st_b_adr  in  12  3 bits per station, r_b_adr.
- st_bypass_b  in  4  B operand is the constant; ignore b_adr.
- st_d_adr  in  16  4 bits per station, r_d_adr; bit3 is write enable, [2:0] is register.
- st_ld_mem  in  4  current uOp loads.
- st_lock_loads  in  4  station blocks younger loads.
- st_lock_reg_wr  in  16  terminal write lock; bit3 is valid, [2:0] is register.
- st_lock_reg_rd  in  36  three 3-bit terminal read locks per station (rd_0, rd_1, rd_2).
- ex_ready  in  1  execution stage accepts a uOp this cycle.
- st_ack  out  4  one-hot, to station sched_ack.
- iss_valid  out  1  a uOp is issued this cycle.
- iss_sel  out  2  index of the issued station; the datapath muxes station fields with it.
- occupancy  out  3  number of allocated stations, 0 to 4.

## Operation
- State: alloc[3:0]; order queue q[0..3] (2-bit station indices, q[0] is oldest); q_cnt[2:0].
- Dispatch:
  - id_ready = ~&alloc.
  - When id_valid & id_ready, st_feed is one-hot on the lowest-index free station.
  - At the clock edge that station's alloc bit is set and its index is appended at q[q_cnt_after_retire].
- Eligibility: station c is eligible when alloc[c] & st_ready[c] and, for every older allocated station o, none of these hold:
  - RAW: lock_reg_wr[o] is valid and equals a_adr[c], or equals b_adr[c] when bypass_b[c]=0.
  - WAW: d_adr[c] bit3 is set and lock_reg_wr[o] is valid with a matching register.
  - WAR: d_adr[c] bit3 is set and d_adr[c][2:0] equals any of rd_0, rd_1 or rd_2 of o.
  - Memory: ld_mem[c] & lock_loads[o].
- Issue:
  - The issue candidate is the eligible station found first scanning q from q[0].
  - iss_valid = candidate exists & ex_ready.
  - iss_sel is the candidate index; it is driven even when ex_ready=0.
  - st_ack is one-hot on iss_sel when iss_valid is high, else 0.
- Retire:
  - When st_ack[i] & st_will_complete[i], clear alloc[i] and remove i from q.
  - Younger entries shift down one slot.
- Same-cycle retire and dispatch: remove first, then append. q_cnt is unchanged. The freed station is not re-dispatched in the same cycle, because id_ready is computed from the current alloc.
- occupancy = q_cnt, registered.
- Decoder contract: it never dispatches with id_iop_init = 000.

## Timing
- Reset: alloc=0, q_cnt=0, q entries=0. Outputs: id_ready=1, st_feed=0, st_ack=0, iss_valid=0, iss_sel=0, occupancy=0.
- st_feed, id_ready, st_ack, iss_valid and iss_sel are combinational from current state and inputs. There is no input-to-output loop through st_feed.
- Dispatch-to-issue latency is at least 1 cycle. A fed station's r_ready is valid from the next cycle.
- Issue happens at most once per cycle; sustained rate is 1 uOp/cycle.
- ex_ready=0 holds st_ack at 0. Station state does not change, so the same candidate is presented again next cycle.
- Reset mid-operation clears all state asynchronously; in-flight stations are reset by the same a_rst.
- Full (q_cnt=4): id_ready=0 and st_feed=0 regardless of id_valid.
- Empty (q_cnt=0): iss_valid=0.

## Test plan
- Reset, then id_valid=1 for 5 cycles with no issue: st_feed is 0001, 0010, 0100, 1000, then 0000 with id_ready=0; occupancy=4.
- Stations 0 and 1 ready and independent, ex_ready=1: st_ack=0001 first. Station 0 will_complete, so next cycle st_ack=0010 and q[0]=1.
- RAW: station 0 (older) lock_reg_wr=1_011, station 1 ready with a_adr=011. Station 1 receives no ack while station 0 is allocated; it issues the cycle after station 0 retires.
- Memory lock: older station lock_loads=1, younger ld_mem=1 and ready: the younger is blocked. A younger ld_mem=0 with no register hazard issues.
- ex_ready=0 for 3 cycles with a candidate present: st_ack=0 and iss_sel stable. ex_ready=1 then gives a single ack.
- Full queue, then retire of station 2 with id_valid=1: the queue compacts (order 0,1,3), id_ready=1 the next cycle, and station 2 is fed and becomes q[3].
